// File: rtl/multicycle_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu_sequencer
// Brief    : Multicycle MIPS main control FSM driving ALU and datapath selects
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu_sequencer #(
    parameter int unsigned ILLEGAL_TRAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic [2:0] o_alu_control,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_pc_src,
    output logic       o_pc_en,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_illegal,
    output logic [3:0] o_state
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_ADD  = 3'b010;
    localparam logic [2:0] c_ALU_PASS = 3'b011;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;
    localparam logic [2:0] c_ALU_SLT  = 3'b111;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_JR     = 4'd13,
        ST_SPARE  = 4'd14,
        ST_HALT   = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_funct_known;
    logic [2:0] w_exec_alu;

    // R-type funct decode; anything outside this set is rejected in DECODE
    always_comb begin
        w_funct_known = 1'b1;
        w_exec_alu    = c_ALU_ADD;
        case (i_funct)
            c_FN_ADD: w_exec_alu = c_ALU_ADD;
            c_FN_SUB: w_exec_alu = c_ALU_SUB;
            c_FN_AND: w_exec_alu = c_ALU_AND;
            c_FN_OR:  w_exec_alu = c_ALU_OR;
            c_FN_SLT: w_exec_alu = c_ALU_SLT;
            default:  w_funct_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = ST_FETCH;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        o_alu_control = 3'b000;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_pc_src      = 2'b00;
        o_iord        = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_reg_dst     = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_illegal     = 1'b0;

        case (r_state)
            ST_RST: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                o_mem_read    = 1'b1;
                o_ir_write    = 1'b1;
                o_alu_src_b   = 2'b01;
                o_alu_control = c_ALU_ADD;
                w_pc_write    = 1'b1;
                w_next_state  = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is computed speculatively into ALUOut
                o_alu_src_b   = 2'b11;
                o_alu_control = c_ALU_ADD;
                case (i_opcode)
                    c_OP_RTYPE: begin
                        if (i_funct == c_FN_JR) begin
                            w_next_state = ST_JR;
                        end else if (w_funct_known) begin
                            w_next_state = ST_EXEC;
                        end else begin
                            o_illegal    = 1'b1;
                            w_next_state = (ILLEGAL_TRAP != 0) ? ST_HALT : ST_FETCH;
                        end
                    end
                    c_OP_LW:   w_next_state = ST_MEMADR;
                    c_OP_SW:   w_next_state = ST_MEMADR;
                    c_OP_BEQ:  w_next_state = ST_BRANCH;
                    c_OP_ADDI: w_next_state = ST_ADDIEX;
                    c_OP_J:    w_next_state = ST_JUMP;
                    default: begin
                        o_illegal    = 1'b1;
                        w_next_state = (ILLEGAL_TRAP != 0) ? ST_HALT : ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 2'b10;
                o_alu_control = c_ALU_ADD;
                w_next_state  = (i_opcode == c_OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                o_mem_read   = 1'b1;
                o_iord       = 1'b1;
                w_next_state = ST_MEMWB;
            end
            ST_MEMWB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_MEMWR: begin
                o_mem_write  = 1'b1;
                o_iord       = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_EXEC: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = w_exec_alu;
                w_next_state  = ST_ALUWB;
            end
            ST_ALUWB: begin
                o_reg_write  = 1'b1;
                o_reg_dst    = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = c_ALU_SUB;
                o_pc_src      = 2'b01;
                w_branch      = 1'b1;
                w_next_state  = ST_FETCH;
            end
            ST_ADDIEX: begin
                o_alu_src_a   = 1'b1;
                o_alu_src_b   = 2'b10;
                o_alu_control = c_ALU_ADD;
                w_next_state  = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                o_reg_write  = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_write   = 1'b1;
                o_pc_src     = 2'b10;
                w_next_state = ST_FETCH;
            end
            ST_JR: begin
                o_alu_src_a   = 1'b1;
                o_alu_control = c_ALU_PASS;
                w_pc_write    = 1'b1;
                o_pc_src      = 2'b11;
                w_next_state  = ST_FETCH;
            end
            ST_HALT: begin
                // Without trapping, HALT is an unreachable encoding and recovers
                w_next_state = (ILLEGAL_TRAP != 0) ? ST_HALT : ST_FETCH;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // zero only matters while the branch comparison is on the ALU
    assign o_pc_en = w_pc_write | (w_branch & i_zero);
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_alu_sequencer
// Brief    : Directed self-checking bench for the multicycle control FSM
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_alu_sequencer;

    logic       clk;
    logic       rst_n;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic       r_zero;

    logic [2:0] w_alu_control, w_t_alu_control;
    logic       w_alu_src_a, w_t_alu_src_a;
    logic [1:0] w_alu_src_b, w_t_alu_src_b;
    logic [1:0] w_pc_src, w_t_pc_src;
    logic       w_pc_en, w_t_pc_en;
    logic       w_iord, w_t_iord;
    logic       w_mem_read, w_t_mem_read;
    logic       w_mem_write, w_t_mem_write;
    logic       w_ir_write, w_t_ir_write;
    logic       w_reg_write, w_t_reg_write;
    logic       w_reg_dst, w_t_reg_dst;
    logic       w_mem_to_reg, w_t_mem_to_reg;
    logic       w_illegal, w_t_illegal;
    logic [3:0] w_state, w_t_state;

    int n_checks;
    int n_errors;

    multicycle_alu_sequencer #(.ILLEGAL_TRAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_opcode(r_opcode), .i_funct(r_funct), .i_zero(r_zero),
        .o_alu_control(w_alu_control), .o_alu_src_a(w_alu_src_a), .o_alu_src_b(w_alu_src_b),
        .o_pc_src(w_pc_src), .o_pc_en(w_pc_en), .o_iord(w_iord),
        .o_mem_read(w_mem_read), .o_mem_write(w_mem_write), .o_ir_write(w_ir_write),
        .o_reg_write(w_reg_write), .o_reg_dst(w_reg_dst), .o_mem_to_reg(w_mem_to_reg),
        .o_illegal(w_illegal), .o_state(w_state)
    );

    multicycle_alu_sequencer #(.ILLEGAL_TRAP(1)) u_dut_trap (
        .clk(clk), .rst_n(rst_n),
        .i_opcode(r_opcode), .i_funct(r_funct), .i_zero(r_zero),
        .o_alu_control(w_t_alu_control), .o_alu_src_a(w_t_alu_src_a), .o_alu_src_b(w_t_alu_src_b),
        .o_pc_src(w_t_pc_src), .o_pc_en(w_t_pc_en), .o_iord(w_t_iord),
        .o_mem_read(w_t_mem_read), .o_mem_write(w_t_mem_write), .o_ir_write(w_t_ir_write),
        .o_reg_write(w_t_reg_write), .o_reg_dst(w_t_reg_dst), .o_mem_to_reg(w_t_mem_to_reg),
        .o_illegal(w_t_illegal), .o_state(w_t_state)
    );

    // All non-state outputs packed: {alu_control, src_a, src_b, pc_src, pc_en, iord,
    // mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal}
    logic [16:0] w_outs, w_t_outs;
    assign w_outs   = {w_alu_control, w_alu_src_a, w_alu_src_b, w_pc_src, w_pc_en, w_iord,
                       w_mem_read, w_mem_write, w_ir_write, w_reg_write, w_reg_dst,
                       w_mem_to_reg, w_illegal};
    assign w_t_outs = {w_t_alu_control, w_t_alu_src_a, w_t_alu_src_b, w_t_pc_src, w_t_pc_en,
                       w_t_iord, w_t_mem_read, w_t_mem_write, w_t_ir_write, w_t_reg_write,
                       w_t_reg_dst, w_t_mem_to_reg, w_t_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        r_opcode = 6'b000000;
        r_funct  = 6'b100010;
        r_zero   = 1'b0;

        // Reset held for three clocks
        repeat (3) step();
        chk("rst_state", 32'(w_state), 32'd0);
        chk("rst_outs", 32'(w_outs), 32'd0);
        chk("rst_trap_outs", 32'(w_t_outs), 32'd0);

        // Release away from the edge; next edge enters FETCH
        #2 rst_n = 1'b1;
        step();
        chk("fetch_state", 32'(w_state), 32'd1);
        chk("fetch_outs", 32'(w_outs), 32'(17'b010_0_01_00_1_0_1_0_1_0_0_0_0));

        // R-type SUB: 1,2,7,8,1 with zero=1 in EXEC having no effect
        step();
        chk("rsub_decode", 32'(w_state), 32'd2);
        chk("decode_outs", 32'(w_outs), 32'(17'b010_0_11_00_0_0_0_0_0_0_0_0_0));
        r_zero = 1'b1;
        step();
        chk("rsub_exec", 32'(w_state), 32'd7);
        chk("rsub_exec_outs", 32'(w_outs), 32'(17'b110_1_00_00_0_0_0_0_0_0_0_0_0));
        step();
        r_zero = 1'b0;
        chk("rsub_aluwb", 32'(w_state), 32'd8);
        chk("rsub_aluwb_outs", 32'(w_outs), 32'(17'b000_0_00_00_0_0_0_0_0_1_1_0_0));
        step();
        chk("rsub_back", 32'(w_state), 32'd1);

        // R-type SLT exercise of EXEC decode
        r_funct = 6'b101010;
        step(); step();
        chk("rslt_exec_alu", 32'(w_alu_control), 32'd7);
        step(); step();

        // lw: 1,2,3,4,5,1
        r_opcode = 6'b100011;
        step();
        step();
        chk("lw_memadr", 32'(w_state), 32'd3);
        chk("lw_memadr_outs", 32'(w_outs), 32'(17'b010_1_10_00_0_0_0_0_0_0_0_0_0));
        step();
        chk("lw_memrd", 32'(w_state), 32'd4);
        chk("lw_memrd_outs", 32'(w_outs), 32'(17'b000_0_00_00_0_1_1_0_0_0_0_0_0));
        step();
        chk("lw_memwb", 32'(w_state), 32'd5);
        chk("lw_memwb_outs", 32'(w_outs), 32'(17'b000_0_00_00_0_0_0_0_0_1_0_1_0));
        step();
        chk("lw_back", 32'(w_state), 32'd1);

        // sw: 1,2,3,6,1
        r_opcode = 6'b101011;
        step(); step(); step();
        chk("sw_memwr", 32'(w_state), 32'd6);
        chk("sw_memwr_outs", 32'(w_outs), 32'(17'b000_0_00_00_0_1_0_1_0_0_0_0_0));
        step();
        chk("sw_back", 32'(w_state), 32'd1);

        // beq taken then not taken, 3 cycles each
        r_opcode = 6'b000100;
        r_zero   = 1'b1;
        step(); step();
        chk("beq_t_state", 32'(w_state), 32'd9);
        chk("beq_t_outs", 32'(w_outs), 32'(17'b110_1_00_01_1_0_0_0_0_0_0_0_0));
        step();
        chk("beq_t_back", 32'(w_state), 32'd1);
        r_zero = 1'b0;
        step(); step();
        chk("beq_nt_state", 32'(w_state), 32'd9);
        chk("beq_nt_pc_en", 32'(w_pc_en), 32'd0);
        step();
        chk("beq_nt_back", 32'(w_state), 32'd1);

        // addi: 1,2,10,11,1
        r_opcode = 6'b001000;
        step(); step();
        chk("addi_ex", 32'(w_state), 32'd10);
        chk("addi_ex_outs", 32'(w_outs), 32'(17'b010_1_10_00_0_0_0_0_0_0_0_0_0));
        step();
        chk("addi_wb_outs", 32'(w_outs), 32'(17'b000_0_00_00_0_0_0_0_0_1_0_0_0));
        step();
        chk("addi_back", 32'(w_state), 32'd1);

        // j: 1,2,12,1
        r_opcode = 6'b000010;
        step(); step();
        chk("j_state", 32'(w_state), 32'd12);
        chk("j_outs", 32'(w_outs), 32'(17'b000_0_00_10_1_0_0_0_0_0_0_0_0));
        step();
        chk("j_back", 32'(w_state), 32'd1);

        // jr: 1,2,13,1
        r_opcode = 6'b000000;
        r_funct  = 6'b001000;
        step(); step();
        chk("jr_state", 32'(w_state), 32'd13);
        chk("jr_outs", 32'(w_outs), 32'(17'b011_1_00_11_1_0_0_0_0_0_0_0_0));
        step();
        chk("jr_back", 32'(w_state), 32'd1);

        // Unknown funct on R-type is illegal
        r_funct = 6'b000000;
        step();
        chk("badfn_illegal", 32'(w_illegal), 32'd1);
        chk("badfn_trap_illegal", 32'(w_t_illegal), 32'd1);
        step();
        chk("badfn_back", 32'(w_state), 32'd1);
        chk("badfn_trap_halt", 32'(w_t_state), 32'd15);

        // Reset clears the trapped instance; then unknown opcode
        #2 rst_n = 1'b0;
        #1 chk("trap_rst_state", 32'(w_t_state), 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        r_opcode = 6'b111111;
        step();
        chk("ill_decode", 32'(w_state), 32'd2);
        chk("ill_pulse", 32'(w_illegal), 32'd1);
        step();
        chk("ill_back", 32'(w_state), 32'd1);
        chk("ill_cleared", 32'(w_illegal), 32'd0);
        chk("ill_trap_halt", 32'(w_t_state), 32'd15);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_hold", 32'({w_t_state, w_t_outs}), 32'({4'd15, 17'd0}));
        end
        #2 rst_n = 1'b0;
        #1 chk("halt_rst", 32'(w_t_state), 32'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_fetch", 32'(w_t_state), 32'd1);

        // Reset dropped mid-MEMWR drops mem_write immediately
        r_opcode = 6'b101011;
        step(); step(); step();
        chk("mid_memwr", 32'(w_mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_write", 32'(w_mem_write), 32'd0);
        chk("async_state", 32'(w_state), 32'd0);
        step();
        chk("async_outs", 32'(w_outs), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
